alu_control_sequencer: RTL
==========================

Name: alu_control_sequencer

Overview:
Parametrised next-generation ALU control unit for the pipelined MIPS core. It decodes aluOp/func into a registered, width-configurable ALU control word with an extended op set (and, or, div). It also sequences multi-cycle operations (mul, div) with a counter-driven FSM, which generates the pipeline stall, a start pulse and a completion strobe. It sits between the main control decoder (ID stage) and the EX-stage ALU and multiply/divide unit.

Parameters:
ALU_CTRL_W, 4, width of alu_ctrl; minimum 3.
MUL_LAT, 4, cycles the multiplier needs; minimum 1.
DIV_LAT, 32, cycles the divider needs; minimum 1.
CNT_W, 6, latency counter width; must hold max(MUL_LAT, DIV_LAT)-1.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
valid_in  in  1  ID stage presents a valid instruction this cycle
aluOp  in  2  ALU op class from main decoder
func  in  6  R-type function field
flush  in  1  synchronous pipeline flush; kills any op in progress
alu_ctrl  out  ALU_CTRL_W  registered ALU operation code
ctrl_valid  out  1  alu_ctrl updated from an accepted instruction this cycle
md_start  out  1  one-cycle start pulse to the mul/div unit
stall  out  1  hold upstream stages; multi-cycle op in progress
result_valid  out  1  one-cycle strobe; multi-cycle result ready
illegal  out  1  one-cycle flag; undefined func accepted

Behaviour:
- Op codes (zero-extended to ALU_CTRL_W): ADD=0, SUB=1, MUL=2, SLT=3, AND=4, OR=5, DIV=6.
- Decode:
  - aluOp 00 -> ADD
  - aluOp 01 -> SUB
  - aluOp 11 -> OR
  - aluOp 10 by func: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x1C MUL, 0x1A DIV; any other func -> ADD with illegal=1.
- Reset (async): state=IDLE, counter=0, all outputs 0 (alu_ctrl=ADD).
- FSM states: IDLE, MULTI, DONE.
- Acceptance: valid_in is accepted only in IDLE or DONE, with flush=0. In MULTI, valid_in is ignored (upstream is stalled).
- Single-cycle op accepted at cycle T:
  - T+1: alu_ctrl=code, ctrl_valid=1, illegal as decoded.
  - Next state IDLE.
- MUL/DIV accepted at cycle T:
  - T+1: alu_ctrl=code, ctrl_valid=1, md_start=1, state=MULTI, counter=LAT-1, stall=1.
  - In MULTI: counter decrements each cycle; counter==0 -> DONE next. Stall is therefore high for exactly LAT cycles (T+1..T+LAT).
  - DONE (T+LAT+1): result_valid=1, stall=0, alu_ctrl held. A valid_in in DONE is accepted as from IDLE.
- stall = (state==MULTI), registered-state decode, glitch-free.
- alu_ctrl holds its last value when nothing is accepted; ctrl_valid, md_start, result_valid and illegal are 0 outside their pulse cycles.
- Flush has priority over everything:
  - Next cycle: state=IDLE, counter=0, stall=0.
  - No result_valid is issued for the killed op.
  - ctrl_valid, md_start and illegal are 0; alu_ctrl is held.
  - A valid_in in the same cycle as flush is dropped.
- Flush in DONE: result_valid has already been issued in that cycle and stands; next cycle follows the flush rules.
- Reset mid-MULTI: immediate return to reset values; no result_valid.
- LAT=1: MULTI lasts one cycle; stall is a single-cycle pulse.

Test Plan:
- Reset, then aluOp=10 func=0x2A valid at T -> T+1 alu_ctrl=3, ctrl_valid=1, stall=0, illegal=0. With no new valid_in, T+2 ctrl_valid=0 and alu_ctrl stays 3.
- aluOp=10 func=0x1C valid at T, MUL_LAT=4:
  - T+1: md_start=1, alu_ctrl=2.
  - T+1..T+4: stall=1.
  - T+5: result_valid=1, stall=0.
- DIV (DIV_LAT=32), valid_in held high with other ops during MULTI -> those ops are ignored. Back-to-back ADD offered in DONE cycle T+33 -> accepted; T+34 alu_ctrl=0, ctrl_valid=1.
- DIV in progress, flush at T+10 -> T+11 stall=0, state IDLE; result_valid never asserts. A valid_in coincident with flush is dropped.
- aluOp=10 func=0x3F valid -> next cycle illegal=1, alu_ctrl=0, ctrl_valid=1. aluOp=11 -> alu_ctrl=5.
- rst asserted asynchronously mid-MUL (between clock edges) -> stall, md_start, result_valid and alu_ctrl read 0 immediately. After release, a new MUL gets full MUL_LAT stall.

Source files
------------

// File: rtl/alu_control_sequencer.sv
// ALU control decoder with a counter-driven sequencer for multi-cycle mul/div operations.
// Produces a registered ALU control word plus stall, start and completion strobes.
module alu_control_sequencer #(
    parameter int unsigned ALU_CTRL_W = 4,
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned DIV_LAT    = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [1:0]            aluOp,
    input  logic [5:0]            func,
    input  logic                  flush,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  ctrl_valid,
    output logic                  md_start,
    output logic                  stall,
    output logic                  result_valid,
    output logic                  illegal
);

    localparam logic [ALU_CTRL_W-1:0] OpAdd = ALU_CTRL_W'(3'd0);
    localparam logic [ALU_CTRL_W-1:0] OpSub = ALU_CTRL_W'(3'd1);
    localparam logic [ALU_CTRL_W-1:0] OpMul = ALU_CTRL_W'(3'd2);
    localparam logic [ALU_CTRL_W-1:0] OpSlt = ALU_CTRL_W'(3'd3);
    localparam logic [ALU_CTRL_W-1:0] OpAnd = ALU_CTRL_W'(3'd4);
    localparam logic [ALU_CTRL_W-1:0] OpOr  = ALU_CTRL_W'(3'd5);
    localparam logic [ALU_CTRL_W-1:0] OpDiv = ALU_CTRL_W'(3'd6);

    // Counter starts at LAT-1 so MULTI lasts exactly LAT cycles.
    localparam logic [CNT_W-1:0] MulCnt = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DivCnt = CNT_W'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StMulti = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ALU_CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic                    ctrl_valid_q, ctrl_valid_d;
    logic                    md_start_q, md_start_d;
    logic                    illegal_q, illegal_d;

    logic [ALU_CTRL_W-1:0]   dec_code;
    logic                    dec_multi;
    logic                    dec_illegal;
    logic [CNT_W-1:0]        dec_cnt;
    logic                    accept;

    always_comb begin
        dec_code    = OpAdd;
        dec_multi   = 1'b0;
        dec_illegal = 1'b0;
        dec_cnt     = '0;
        unique case (aluOp)
            2'b00: dec_code = OpAdd;
            2'b01: dec_code = OpSub;
            2'b11: dec_code = OpOr;
            default: begin
                unique case (func)
                    6'h20: dec_code = OpAdd;
                    6'h22: dec_code = OpSub;
                    6'h24: dec_code = OpAnd;
                    6'h25: dec_code = OpOr;
                    6'h2A: dec_code = OpSlt;
                    6'h1C: begin
                        dec_code  = OpMul;
                        dec_multi = 1'b1;
                        dec_cnt   = MulCnt;
                    end
                    6'h1A: begin
                        dec_code  = OpDiv;
                        dec_multi = 1'b1;
                        dec_cnt   = DivCnt;
                    end
                    default: begin
                        dec_code    = OpAdd;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Upstream is stalled during MULTI, so any valid_in seen there is stale.
    assign accept = valid_in && !flush && (state_q != StMulti);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_ctrl_d   = alu_ctrl_q;
        ctrl_valid_d = 1'b0;
        md_start_d   = 1'b0;
        illegal_d    = 1'b0;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StMulti: begin
                    if (cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    if (accept) begin
                        alu_ctrl_d   = dec_code;
                        ctrl_valid_d = 1'b1;
                        illegal_d    = dec_illegal;
                        if (dec_multi) begin
                            md_start_d = 1'b1;
                            state_d    = StMulti;
                            cnt_d      = dec_cnt;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            alu_ctrl_q   <= OpAdd;
            ctrl_valid_q <= 1'b0;
            md_start_q   <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_ctrl_q   <= alu_ctrl_d;
            ctrl_valid_q <= ctrl_valid_d;
            md_start_q   <= md_start_d;
            illegal_q    <= illegal_d;
        end
    end

    assign alu_ctrl     = alu_ctrl_q;
    assign ctrl_valid   = ctrl_valid_q;
    assign md_start     = md_start_q;
    assign illegal      = illegal_q;
    assign stall        = (state_q == StMulti);
    assign result_valid = (state_q == StDone);

endmodule
